// File: rtl/hazard_pkg.sv
// Shared definitions for the ID-stage hazard detector: hazard cause encodings
// and default multi-cycle HI/LO latencies.
package hazard_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE      = 2'd0,
    CAUSE_LOAD_USE  = 2'd1,
    CAUSE_BRANCH_OP = 2'd2,
    CAUSE_MULDIV    = 2'd3
  } cause_e;

  localparam int DEFAULT_MULT_CYCLES = 4;
  localparam int DEFAULT_DIV_CYCLES  = 32;
  localparam int DEFAULT_CNT_WIDTH   = 6;

endpackage

// File: rtl/muldiv_busy_counter.sv
// Down-counter tracking how many more cycles the HI/LO unit stays busy after a
// MULT/DIV issues. Busy is asserted while the count is nonzero.
module muldiv_busy_counter #(
  parameter int CntWidth = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [CntWidth-1:0] loadValue,
  output logic                busy
);

  logic [CntWidth-1:0] count;

  // NOTE: reset is tested before load, so an issue coincident with reset is dropped.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/hazard_detector.sv
// ID-stage hazard detector: flags load-use, branch-operand and HI/LO busy
// hazards for the stall unit and counts stall cycles for performance readout.
module hazard_detector
  import hazard_pkg::*;
#(
  parameter int MultCycles = DEFAULT_MULT_CYCLES,
  parameter int DivCycles  = DEFAULT_DIV_CYCLES,
  parameter int CntWidth   = DEFAULT_CNT_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  IDRs,
  input  logic [4:0]  IDRt,
  input  logic        IDUsesRs,
  input  logic        IDUsesRt,
  input  logic        IDIsBranch,
  input  logic        IDIsMulDiv,
  input  logic        IDIsDiv,
  input  logic        IDReadsHiLo,
  input  logic        EXMemRead,
  input  logic        EXRegWrite,
  input  logic [4:0]  EXWriteReg,
  input  logic        MEMMemRead,
  input  logic [4:0]  MEMWriteReg,
  input  logic        IDEXWriteEN,
  input  logic        IDEXClear,
  output logic        HazardHappen,
  output logic [1:0]  HazardCause,
  output logic        MulDivBusy,
  output logic [31:0] StallCount
);

  if (MultCycles < 1 || DivCycles < 1 ||
      MultCycles >= (1 << CntWidth) || DivCycles >= (1 << CntWidth)) begin : gParamCheck
    $error("hazard_detector: MultCycles/DivCycles must be in 1 .. 2**CntWidth-1");
  end

  localparam logic [CntWidth-1:0] MultLoad = CntWidth'(MultCycles);
  localparam logic [CntWidth-1:0] DivLoad  = CntWidth'(DivCycles);

  // Register 0 is hardwired to zero, so writing it never creates a dependency.
  function automatic logic srcHit(input logic [4:0] rs, input logic [4:0] rt,
                                  input logic usesRs, input logic usesRt,
                                  input logic [4:0] dest);
    return (dest != 5'd0) &&
           ((usesRs && (rs == dest)) || (usesRt && (rt == dest)));
  endfunction

  logic   exHit, memHit;
  logic   loadUse, branchOp, mulDivHazard;
  logic   issue;
  cause_e cause;

  assign exHit  = srcHit(IDRs, IDRt, IDUsesRs, IDUsesRt, EXWriteReg);
  assign memHit = srcHit(IDRs, IDRt, IDUsesRs, IDUsesRt, MEMWriteReg);

  assign loadUse      = EXMemRead && exHit;
  assign branchOp     = IDIsBranch && ((EXRegWrite && exHit) || (MEMMemRead && memHit));
  assign mulDivHazard = MulDivBusy && (IDReadsHiLo || IDIsMulDiv);

  // NOTE: the default is assigned first so no path leaves cause unassigned (no latch).
  always_comb begin
    cause = CAUSE_NONE;
    if (loadUse) begin
      cause = CAUSE_LOAD_USE;
    end else if (branchOp) begin
      cause = CAUSE_BRANCH_OP;
    end else if (mulDivHazard) begin
      cause = CAUSE_MULDIV;
    end
  end

  assign HazardHappen = (cause != CAUSE_NONE);
  assign HazardCause  = cause;

  // A busy hazard makes the stall unit clear ID/EX, so issue never overlaps busy.
  assign issue = IDIsMulDiv && IDEXWriteEN && !IDEXClear;

  muldiv_busy_counter #(
    .CntWidth (CntWidth)
  ) uBusyCounter (
    .clk       (clk),
    .rst       (rst),
    .load      (issue),
    .loadValue (IDIsDiv ? DivLoad : MultLoad),
    .busy      (MulDivBusy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      StallCount <= '0;
    end else if (HazardHappen && (StallCount != 32'hFFFF_FFFF)) begin
      StallCount <= StallCount + 32'd1;
    end
  end

endmodule

// File: doc/hazard_detector.md
# hazard_detector

Producer side of the pipeline stall handshake: detects data and structural hazards in the ID stage and drives `HazardHappen` into the stall unit, which answers with PC/IF-ID/ID-EX enables and clears. Covers load-use, branch-operand-in-ID and multi-cycle MULT/DIV (HI/LO) hazards. Tracks the in-flight MULT/DIV with a down-counter fed back from the stall unit's ID/EX controls. Also keeps a saturating stall-cycle counter for performance readout.

## Interface
Parameters:
- `MultCycles`, 4: HI/LO busy cycles after a MULT/MULTU issues.
- `DivCycles`, 32: HI/LO busy cycles after a DIV/DIVU issues.
- `CntWidth`, 6: busy counter width; `DivCycles` and `MultCycles` must be < 2^`CntWidth`.

Ports:
- `clk`  in  1  system clock. One clock; all state on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `IDRs`, `IDRt`  in  5 each  ID source register numbers.
- `IDUsesRs`, `IDUsesRt`  in  1 each  ID instruction reads that source.
- `IDIsBranch`  in  1  ID instruction is a branch/jr resolved in ID.
- `IDIsMulDiv`  in  1  ID instruction is MULT/MULTU/DIV/DIVU.
- `IDIsDiv`  in  1  qualifies `IDIsMulDiv`: 1 = divide.
- `IDReadsHiLo`  in  1  ID instruction is MFHI/MFLO/MTHI/MTLO.
- `EXMemRead`, `EXRegWrite`  in  1 each  from ID/EX register.
- `EXWriteReg`  in  5  EX destination.
- `MEMMemRead`  in  1  from EX/MEM register.
- `MEMWriteReg`  in  5  MEM destination.
- `IDEXWriteEN`, `IDEXClear`  in  1 each  from the stall unit.
- `HazardHappen`  out  1  to the stall unit.
- `HazardCause`  out  2  0 none, 1 load-use, 2 branch-operand, 3 muldiv-busy.
- `MulDivBusy`  out  1  busy counter nonzero.
- `StallCount`  out  32  saturating count of hazard cycles.

## Operation
- Match(r, d): `r == d && d != 0`. Register 0 never causes a hazard.
- SrcHit(d): (`IDUsesRs` && Match(`IDRs`, d)) || (`IDUsesRt` && Match(`IDRt`, d)).
- Load-use: `EXMemRead` && SrcHit(`EXWriteReg`).
- Branch-operand: `IDIsBranch` && ((`EXRegWrite` && SrcHit(`EXWriteReg`)) || (`MEMMemRead` && SrcHit(`MEMWriteReg`))).
- Muldiv-busy: `MulDivBusy` && (`IDReadsHiLo` || `IDIsMulDiv`).
- `HazardHappen` is the OR of the three. `HazardCause` uses priority load-use > branch-operand > muldiv-busy, and is 0 when there is no hazard.
- Issue = `IDIsMulDiv` && `IDEXWriteEN` && !`IDEXClear`. Issue is never true while busy, because a busy hazard forces `IDEXClear`.
- Busy counter:
  - on issue, load `DivCycles` if `IDIsDiv`, else `MultCycles`;
  - otherwise decrement when nonzero;
  - hold at 0.
- `MulDivBusy` = counter != 0.
- `StallCount` increments each cycle `HazardHappen` is 1 and saturates at 32'hFFFFFFFF.
- Branch and hazard together: the stall unit flags this itself, and this block takes no special action. The issue gating above still applies: when the stall unit clears nothing, a mult/div in ID issues normally.

## Timing
- `HazardHappen`, `HazardCause`: combinational from inputs and registered state, with zero latency in the same cycle.
- `MulDivBusy`: registered. It is 1 starting the cycle after issue and lasts exactly N cycles (N = `MultCycles` or `DivCycles`).
- Load then dependent ALU op: 1 stall cycle.
- Load then dependent branch: 2 stall cycles (load-use, then branch-operand from MEM).
- ALU op then dependent branch: 1 stall cycle.
- Reset values: counter 0, `StallCount` 0, `MulDivBusy` 0. `HazardHappen` then follows inputs only.
- Reset mid-operation: a `rst` asserted while busy zeroes the counter on that edge, and a pending issue is discarded.
- Issue with `CntWidth` overflow is a parameter error, checked at elaboration.

## Structure
- Shared package `hazard_pkg`:
  - cause encodings (`CAUSE_NONE`, `CAUSE_LOAD_USE`, `CAUSE_BRANCH_OP`, `CAUSE_MULDIV`);
  - default latency constants.
- Sub-module `muldiv_busy_counter`:
  - inputs: `clk`, `rst`, load, load value;
  - output: busy.
- The top level holds the comparators, priority encode and `StallCount`.

## Test plan
- Load-use: EX `lw $5`, ID `add` reading `$5` -> `HazardHappen`=1, `HazardCause`=1 for one cycle, `StallCount` 0 -> 1.
- Register 0: EX `lw $0`, ID reads `$0` -> `HazardHappen`=0.
- Load then branch: `lw $8` followed by `beq $8,$9` -> stall cycle 1 with cause 1, stall cycle 2 with cause 2, then release; `StallCount`=2.
- Mult then MFLO:
  - `mult` issues with `IDEXWriteEN`=1, `IDEXClear`=0;
  - `MulDivBusy` is 1 for 4 cycles;
  - `mflo` in ID stalls with cause 3 until busy drops, then issues.
- Div then mult: `div` issues, then `mult` in ID -> 32 busy cycles with cause 3; `mult` issues on the first non-busy cycle; a new count of 4 loads.
- Reset mid-divide: `rst`=1 at busy cycle 10 -> next cycle `MulDivBusy`=0 and `StallCount`=0; `mfhi` in ID -> no hazard.
